kbd_spi_master: RTL
===================

// Module: kbd_spi_master
// PURPOSE
//  FPGA-side SPI master for the slave keyboard/reset protocol. It serialises an 8x5 key
//  matrix into a 40-bit key frame, or sends a reset command byte, to any slave that
//  decodes that protocol; spidi is captured during key frames.
//  Used by test rigs and any FPGA that drives a ZX-keyboard/reset slave.
// PARAMETERS
//  HALF_DIV  4  fclk cycles per spick half-period (>=2)
//  GAP_HALF  2  idle half-periods between frame phases / CS edges (>=1)
// PORTS
//  fclk        in   1   system clock; all logic on posedge fclk
//  rst         in   1   synchronous active-high reset
//  kbd_start   in   1   1-cycle request: send key frame
//  kbd_matrix  in   40  bit r*5+c = row r (A8+r), column c (D0+c); 1 = pressed
//  rst_start   in   1   1-cycle request: send reset command
//  rst_rom     in   2   ROM page delivered with the reset command
//  busy        out  1   frame in progress; starts ignored while high
//  done        out  1   1-cycle pulse when a frame completes
//  rx_data     out  40  spidi bits of the last key frame; bit i = i-th sample
//  spics_n     out  1   chip select, active low
//  spick       out  1   serial clock, idles low
//  spido       out  1   MOSI
//  spidi       in   1   MISO
// BEHAVIOUR
//  Reset: spics_n=1, spick=0, spido=0, busy=0, done=0, rx_data=0, FSM=IDLE, divider=0.
//  Timing base: a half-period tick every HALF_DIV fclk cycles while busy.
//  spido changes only while spick is low; spick rises mid-bit; spidi is sampled on the
//  fclk cycle that raises spick.
//  Start: a start is accepted in IDLE only. kbd_matrix/rst_rom are latched on accept.
//   busy rises on the next cycle. If kbd_start and rst_start arrive together, reset wins.
//  Key frame (slave shifts only while CS low, LSB-first into a 40-bit register):
//   K_SETUP: spics_n=0 and bit0 is on spido for GAP_HALF half-periods.
//   K_SHIFT: 40 clocks. Tx bit i (i=0..39) = kbd_matrix[(i%8)*5 + (4 - i/8)], so the
//    slave ends with reg[8*(4-c)+r] = key(r,c).
//   K_HOLD: spick low for GAP_HALF half-periods, then spics_n=1. The slave snapshots on
//    this rising CS edge. done pulses on the cycle spics_n rises.
//  Reset frame (slave register clears while CS low and shifts while CS high):
//   R_CLR: spics_n=0 for GAP_HALF half-periods, which clears the slave register.
//   R_LEAD: spics_n=1 for GAP_HALF half-periods.
//   R_SHIFT: 8 clocks, byte {2'b00, rst_rom, 2'b00, 1'b1, 1'b0} sent LSB-first.
//    bit0=0 ensures slave genrst is asserted only after the 8th rising edge, so rstrom
//    latches rst_rom on the 8th falling edge.
//   R_TAIL: spick low for GAP_HALF half-periods.
//   R_CLR2: spics_n=0 for GAP_HALF half-periods, which clears genrst. Then spics_n=1.
//    done pulses on that cycle.
//  FSM: IDLE -> K_SETUP -> K_SHIFT -> K_HOLD -> IDLE
//       IDLE -> R_CLR -> R_LEAD -> R_SHIFT -> R_TAIL -> R_CLR2 -> IDLE
//  Counters: bit counter 6 bits, terminal value 39 or 7. Divider wraps at HALF_DIV-1.
//   Neither counter wraps into a next frame: the FSM returns to IDLE first.
//  After rst mid-frame: spics_n=1 and spick=0 on the next cycle. The partial frame is
//   abandoned and the slave discards it (key register is not snapshotted; reset byte
//   shift restarts).
//  rx_data updates atomically at done, for key frames only. Reset frames leave it unchanged.
//  Done and busy: busy falls on the done cycle. A new start is accepted from the next
//   cycle.
// TESTING
//  1 key(0,0) only (kbd_matrix=40'h1) -> only tx bit 32 high. 40 spick pulses in one CS-low
//    window; slave model keyout=5'b11110 with a[8]=0, 5'b11111 with a[8]=1.
//  2 kbd_matrix=all ones, spidi tied 1 -> 40 high bits, rx_data=40'hFF_FFFF_FFFF, done
//    once, busy low after.
//  3 rst_start with rst_rom=2'b10 -> MOSI byte 8'h22 with CS high. Slave model
//    rstrom=2'b10, genrst high only between 8th rise and R_CLR2 CS fall.
//  4 kbd_start and rst_start in the same cycle -> reset frame only. A kbd_start issued
//    while busy is ignored (no second frame).
//  5 rst asserted at bit 20 of a key frame -> next cycle spics_n=1, spick=0, busy=0.
//    Slave keyreg unchanged; a following frame completes correctly.
//  6 HALF_DIV=2 and HALF_DIV=7 -> spick period 4 and 14 fclk. Frame length, in fclk
//    cycles, matches formula.

Source files
------------

// File: rtl/kbd_spi_master.sv
// SPI master for the keyboard/reset slave protocol.
// Sends either a 40-bit key frame (CS low, LSB-first, spidi captured) or a
// reset command byte shifted while CS is high, framed by CS-low clear windows.
// All timing is counted in spick half-periods of HALF_DIV fclk cycles.
module kbd_spi_master #(
    parameter int HALF_DIV = 4,
    parameter int GAP_HALF = 2
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        kbd_start,
    input  logic [39:0] kbd_matrix,
    input  logic        rst_start,
    input  logic [1:0]  rst_rom,
    output logic        busy,
    output logic        done,
    output logic [39:0] rx_data,
    output logic        spics_n,
    output logic        spick,
    output logic        spido,
    input  logic        spidi
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_HALF + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_HALF - 1);

    typedef enum logic [3:0] {
        IDLE,
        K_SETUP,
        K_SHIFT,
        K_HOLD,
        R_CLR,
        R_LEAD,
        R_SHIFT,
        R_TAIL,
        R_CLR2
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [GAP_W-1:0]   gap_cnt;
    logic [5:0]         bit_cnt;
    logic [39:0]        tx_sr;
    logic [39:0]        rx_sr;
    logic [39:0]        key_bits;
    logic               tick;
    logic               gap_done;
    logic               in_shift;
    logic [5:0]         last_bit;

    // Reorders the matrix so that tx bit i carries key(i%8, 4-i/8); the slave
    // then holds key(r,c) at register bit 8*(4-c)+r.
    function automatic logic [39:0] key_order(input logic [39:0] m);
        logic [39:0] t;
        logic [5:0]  idx;
        t = '0;
        for (int i = 0; i < 40; i++) begin
            idx  = 6'((i % 8) * 5 + 4 - (i / 8));
            t[i] = m[idx];
        end
        return t;
    endfunction

    // Reset command byte; bit0 is 0 so genrst only appears after the 8th edge.
    function automatic logic [7:0] rst_byte(input logic [1:0] rom);
        return {2'b00, rom, 2'b00, 1'b1, 1'b0};
    endfunction

    assign key_bits = key_order(kbd_matrix);
    assign tick     = busy && (div == DIV_LAST);
    assign gap_done = (gap_cnt == GAP_LAST);
    assign in_shift = (state == K_SHIFT) || (state == R_SHIFT);
    assign last_bit = (state == K_SHIFT) ? 6'd39 : 6'd7;

    // Frame sequencer: divider, gap/bit counters, SPI pins and handshake.
    always_ff @(posedge fclk) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            spics_n <= 1'b1;
            spick   <= 1'b0;
            spido   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (busy) begin
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end

            if (tick && !in_shift) begin
                gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rst_start) begin
                        tx_sr   <= {32'd0, rst_byte(rst_rom)};
                        state   <= R_CLR;
                        busy    <= 1'b1;
                        spics_n <= 1'b0;
                        spido   <= 1'b0;
                    end else if (kbd_start) begin
                        tx_sr   <= key_bits;
                        state   <= K_SETUP;
                        busy    <= 1'b1;
                        spics_n <= 1'b0;
                        spido   <= key_bits[0];
                    end
                end

                K_SETUP: begin
                    if (tick && gap_done) begin
                        state <= K_SHIFT;
                    end
                end

                K_SHIFT, R_SHIFT: begin
                    if (tick) begin
                        if (!spick) begin
                            spick          <= 1'b1;
                            rx_sr[bit_cnt] <= spidi;
                        end else begin
                            spick <= 1'b0;
                            if (bit_cnt == last_bit) begin
                                bit_cnt <= '0;
                                spido   <= 1'b0;
                                state   <= (state == K_SHIFT) ? K_HOLD : R_TAIL;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                spido   <= tx_sr[bit_cnt + 6'd1];
                            end
                        end
                    end
                end

                K_HOLD: begin
                    if (tick && gap_done) begin
                        spics_n <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        rx_data <= rx_sr;
                        state   <= IDLE;
                    end
                end

                R_CLR: begin
                    if (tick && gap_done) begin
                        spics_n <= 1'b1;
                        state   <= R_LEAD;
                    end
                end

                R_LEAD: begin
                    if (tick && gap_done) begin
                        spido <= tx_sr[0];
                        state <= R_SHIFT;
                    end
                end

                R_TAIL: begin
                    if (tick && gap_done) begin
                        spics_n <= 1'b0;
                        state   <= R_CLR2;
                    end
                end

                R_CLR2: begin
                    if (tick && gap_done) begin
                        spics_n <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
